// File: rtl/add_seq_driver.sv
// Two-beat operand initiator: takes an operand pair on a valid/ready request port,
// issues it to an adder responder as p_seq=1/2 beats, and returns the sum (or a timeout) on a valid/ready response port.
module add_seq_driver #(
    parameter int unsigned W       = 4,
    parameter int unsigned TIMEOUT = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [W-1:0] req_a,
    input  logic [W-1:0] req_b,
    output logic [W-1:0] p,
    output logic [1:0]   p_seq,
    input  logic         res_valid,
    input  logic [W-1:0] s,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_sum,
    output logic         rsp_carry,
    output logic         rsp_timeout,
    output logic         busy
);

    localparam int unsigned CW = $clog2(TIMEOUT);

    typedef enum logic [2:0] {IDLE, SEND_P1, SEND_P2, WAIT_RES, RESP} state_t;

    state_t        state, state_n;
    logic [W-1:0]  b_q, b_n;
    logic          carry_q, carry_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [W-1:0]  p_n;
    logic [1:0]    p_seq_n;
    logic          rsp_valid_n, rsp_carry_n, rsp_timeout_n;
    logic [W-1:0]  rsp_sum_n;
    logic [W:0]    local_sum;

    assign req_ready = (state == IDLE) && !rst;
    assign busy      = (state != IDLE);
    assign local_sum = {1'b0, req_a} + {1'b0, req_b};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            b_q         <= '0;
            carry_q     <= 1'b0;
            cnt         <= '0;
            p           <= '0;
            p_seq       <= 2'd0;
            rsp_valid   <= 1'b0;
            rsp_sum     <= '0;
            rsp_carry   <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            state       <= state_n;
            b_q         <= b_n;
            carry_q     <= carry_n;
            cnt         <= cnt_n;
            p           <= p_n;
            p_seq       <= p_seq_n;
            rsp_valid   <= rsp_valid_n;
            rsp_sum     <= rsp_sum_n;
            rsp_carry   <= rsp_carry_n;
            rsp_timeout <= rsp_timeout_n;
        end
    end

    always_comb begin
        state_n       = state;
        b_n           = b_q;
        carry_n       = carry_q;
        cnt_n         = cnt;
        p_n           = p;
        p_seq_n       = p_seq;
        rsp_valid_n   = rsp_valid;
        rsp_sum_n     = rsp_sum;
        rsp_carry_n   = rsp_carry;
        rsp_timeout_n = rsp_timeout;
        unique case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    b_n     = req_b;
                    carry_n = local_sum[W];
                    p_n     = req_a;
                    p_seq_n = 2'd1;
                    state_n = SEND_P1;
                end
            end
            SEND_P1: begin
                p_n     = b_q;
                p_seq_n = 2'd2;
                state_n = SEND_P2;
            end
            SEND_P2: begin
                p_n     = '0;
                p_seq_n = 2'd0;
                cnt_n   = '0;
                state_n = WAIT_RES;
            end
            WAIT_RES: begin
                // A result arriving on the last counted cycle takes priority over the timeout.
                if (res_valid) begin
                    rsp_sum_n     = s;
                    rsp_carry_n   = carry_q;
                    rsp_timeout_n = 1'b0;
                    rsp_valid_n   = 1'b1;
                    state_n       = RESP;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    rsp_sum_n     = '0;
                    rsp_carry_n   = 1'b0;
                    rsp_timeout_n = 1'b1;
                    rsp_valid_n   = 1'b1;
                    state_n       = RESP;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            RESP: begin
                if (rsp_valid && rsp_ready) begin
                    rsp_valid_n = 1'b0;
                    state_n     = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_add_seq_driver.sv
// Directed bench for add_seq_driver with a configurable-latency adder responder.
module tb_add_seq_driver;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [3:0] req_a = '0;
    logic [3:0] req_b = '0;
    logic [3:0] p;
    logic [1:0] p_seq;
    logic       res_valid;
    logic [3:0] s;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [3:0] rsp_sum;
    logic       rsp_carry;
    logic       rsp_timeout;
    logic       busy;

    int errors = 0;
    int checks = 0;

    // Responder settings: rsp_en=0 never answers; rsp_delay adds cycles after the second beat.
    logic       rsp_en = 1'b1;
    int         rsp_delay = 0;
    logic       armed;
    int         cd;
    logic [3:0] ra, rb;

    add_seq_driver #(.W(4), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .p(p), .p_seq(p_seq),
        .res_valid(res_valid), .s(s), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_sum(rsp_sum), .rsp_carry(rsp_carry), .rsp_timeout(rsp_timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid <= 1'b0; s <= '0; armed <= 1'b0; cd <= 0; ra <= '0; rb <= '0;
        end else if (p_seq == 2'd1) begin
            ra <= p; res_valid <= 1'b0; armed <= 1'b0;
        end else if (p_seq == 2'd2 && rsp_en) begin
            if (rsp_delay == 0) begin
                res_valid <= 1'b1; s <= ra + p;
            end else begin
                armed <= 1'b1; cd <= rsp_delay - 1; rb <= p;
            end
        end else if (armed) begin
            if (cd == 0) begin
                res_valid <= 1'b1; s <= ra + rb; armed <= 1'b0;
            end else begin
                cd <= cd - 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request; the accepting edge is E0.
    task automatic issue(input logic [3:0] a, input logic [3:0] b);
        req_a = a; req_b = b; req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        check("e0_p", p, a);
        check("e0_pseq", p_seq, 1);
        check("e0_busy", busy, 1);
    endtask

    // Follows a transaction from E0 to the response; latency counted in edges after E0.
    task automatic track(input logic [3:0] b, input int lat_exp, input logic [3:0] sum_exp,
                         input logic carry_exp, input logic to_exp, input logic release_rsp);
        int lat;
        step();
        check("e1_p", p, b);
        check("e1_pseq", p_seq, 2);
        step();
        check("e2_pseq", p_seq, 0);
        lat = 2;
        while (!rsp_valid && lat < 40) begin
            step();
            lat++;
        end
        check("latency", lat, lat_exp);
        check("rsp_sum", rsp_sum, sum_exp);
        check("rsp_carry", rsp_carry, carry_exp);
        check("rsp_timeout", rsp_timeout, to_exp);
        if (release_rsp) begin
            rsp_ready = 1'b1;
            step();
            rsp_ready = 1'b0;
            check("release_busy", busy, 0);
            check("release_valid", rsp_valid, 0);
        end
    endtask

    initial begin
        logic seen;
        // Reset values
        step();
        step();
        check("rst_p", p, 0);
        check("rst_pseq", p_seq, 0);
        check("rst_valid", rsp_valid, 0);
        check("rst_sum", rsp_sum, 0);
        check("rst_carry", rsp_carry, 0);
        check("rst_to", rsp_timeout, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", req_ready, 0);
        rst = 1'b0;
        #1;
        check("post_rst_ready", req_ready, 1);
        check("post_rst_pseq", p_seq, 0);

        // Basic sum, single-cycle responder
        rsp_en = 1'b1; rsp_delay = 0;
        issue(4'd2, 4'd3);
        track(4'd3, 3, 4'd5, 1'b0, 1'b0, 1'b1);

        // Overflow with a responder two cycles late
        rsp_delay = 2;
        issue(4'd9, 4'd8);
        track(4'd8, 5, 4'd1, 1'b1, 1'b0, 1'b1);

        // Timeout, then a normal transaction
        rsp_en = 1'b0;
        issue(4'd7, 4'd6);
        track(4'd6, 10, 4'd0, 1'b0, 1'b1, 1'b1);
        rsp_en = 1'b1; rsp_delay = 0;
        issue(4'd15, 4'd15);
        track(4'd15, 3, 4'd14, 1'b1, 1'b0, 1'b1);

        // Result on the last counted cycle beats the timeout
        rsp_delay = 7;
        issue(4'd5, 4'd10);
        track(4'd10, 10, 4'd15, 1'b0, 1'b0, 1'b1);

        // One cycle later the timeout wins; the stale res_valid is then ignored
        rsp_delay = 8;
        issue(4'd8, 4'd8);
        track(4'd8, 10, 4'd0, 1'b0, 1'b1, 1'b1);
        rsp_delay = 0;
        issue(4'd6, 4'd3);
        track(4'd3, 3, 4'd9, 1'b0, 1'b0, 1'b1);

        // Backpressure with a second request pending
        issue(4'd4, 4'd5);
        track(4'd5, 3, 4'd9, 1'b0, 1'b0, 1'b0);
        req_a = 4'd6; req_b = 4'd7; req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_valid", rsp_valid, 1);
            check("bp_sum", rsp_sum, 9);
            check("bp_ready", req_ready, 0);
            check("bp_pseq", p_seq, 0);
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("bp_idle", busy, 0);
        check("bp_req_ready", req_ready, 1);
        step();
        req_valid = 1'b0;
        check("bp_acc_p", p, 6);
        check("bp_acc_pseq", p_seq, 1);
        track(4'd7, 3, 4'd13, 1'b0, 1'b0, 1'b1);

        // Reset during SEND_P2
        issue(4'd3, 4'd4);
        step();
        check("mid_pseq_pre", p_seq, 2);
        rst = 1'b1;
        #1;
        check("mid_pseq", p_seq, 0);
        check("mid_busy", busy, 0);
        check("mid_ready", req_ready, 0);
        step();
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (rsp_valid) seen = 1'b1;
        end
        check("mid_no_rsp", seen, 0);
        issue(4'd1, 4'd1);
        track(4'd1, 3, 4'd2, 1'b0, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/add_seq_driver.md
# add_seq_driver

Initiator for the two-beat operand protocol (`p` / `p_seq`) used by the sequential adder FSMs. It accepts an operand pair on a valid/ready request port, issues it to an adder responder as two consecutive beats (`p_seq`=1 then `p_seq`=2), waits for `res_valid` with a bounded timeout, and returns the sum on a valid/ready response port. It sits between a bus-side requester and any adder variant, Mealy or Moore, with any response latency up to `TIMEOUT`.

## Interface
- `W`, default 4: operand and sum width.
- `TIMEOUT`, default 8: maximum cycles spent in WAIT_RES before aborting; must be ≥ 2.

- `clk`  in  1  sole clock; all logic on the rising edge.
- `rst`  in  1  reset; one clock; asynchronous and active-high.
- `req_valid`  in  1  operand pair offered.
- `req_ready`  out  1  `(state==IDLE) && !rst`.
- `req_a`  in  W  first operand.
- `req_b`  in  W  second operand.
- `p`  out  W  operand to responder, registered.
- `p_seq`  out  2  beat tag to responder, registered: 0 none, 1 first, 2 second.
- `res_valid`  in  1  responder result valid.
- `s`  in  W  responder sum.
- `rsp_valid`  out  1  response held.
- `rsp_ready`  in  1  response consumer ready.
- `rsp_sum`  out  W  returned sum.
- `rsp_carry`  out  1  carry-out of `req_a + req_b`, computed locally.
- `rsp_timeout`  out  1  response produced by timeout.
- `busy`  out  1  `state != IDLE`.

## Operation
- States are IDLE, SEND_P1, SEND_P2, WAIT_RES, RESP.
- **IDLE**
  - On `req_valid && req_ready`: latch `a`, `b` and the carry of `a+b` computed at W+1 bits.
  - Drive `p<=a`, `p_seq<=1`, go to SEND_P1.
- **SEND_P1**: `p<=b`, `p_seq<=2`, go to SEND_P2. Exactly one cycle.
- **SEND_P2**: `p<=0`, `p_seq<=0`, timeout counter cleared, go to WAIT_RES. Exactly one cycle.
- **WAIT_RES**: `p_seq` stays 0. Each edge:
  - If `res_valid`: `rsp_sum<=s`, `rsp_carry<=`latched carry, `rsp_timeout<=0`, `rsp_valid<=1`, go to RESP.
  - Else if `cnt==TIMEOUT-1`: `rsp_sum<=0`, `rsp_carry<=0`, `rsp_timeout<=1`, `rsp_valid<=1`, go to RESP.
  - Else `cnt<=cnt+1`.
- **RESP**: all `rsp_*` outputs held stable. On `rsp_valid && rsp_ready`: `rsp_valid<=0`, go to IDLE.
- `res_valid` is sampled only in WAIT_RES. A level-held `res_valid` from a previous transaction is ignored elsewhere; the responder clears it on the `p_seq`=1 beat.
- Arithmetic: `rsp_sum` is the responder's `s` passed through unchanged, modulo 2^W. Width of `cnt` is `$clog2(TIMEOUT)`.
- Only one transaction is in flight; there is no request buffering.

## Timing
- Reset asserted, in any state, immediately:
  - state=IDLE;
  - `p`=0, `p_seq`=0, `rsp_valid`=0, `rsp_sum`=0, `rsp_carry`=0, `rsp_timeout`=0, `busy`=0, `req_ready`=0.
  - An in-flight transaction is dropped with no response.
- Reset released: `req_ready`=1 in the same cycle.
- Request accepted at edge E0:
  - `p_seq`=1 during E0–E1;
  - `p_seq`=2 during E1–E2;
  - `p_seq`=0 from E2.
- With a single-cycle registered responder, `res_valid` is high during E2–E3 and `rsp_valid` rises after E3. Minimum latency is 3 cycles.
- Timeout: `rsp_valid` rises at the edge E2+TIMEOUT.
- If `res_valid` is seen at the edge where `cnt==TIMEOUT-1`, the result wins and `rsp_timeout`=0.
- `rsp_ready` held high in RESP: IDLE is reached one edge after `rsp_valid` rises. Minimum 4 edges per transaction, never overlapped.
- `req_valid` asserted outside IDLE is ignored; the requester must hold it until `req_ready`.

## Test plan
- **Reset values.** Hold `rst`=1 for 2 cycles → all outputs 0 as listed. Release → `req_ready`=1, `p_seq`=0.
- **Basic sum, single-cycle responder.** a=2, b=3 against a single-cycle registered responder → `p`/`p_seq` = 2/1 then 3/2 on consecutive cycles. `rsp_valid` 3 cycles after accept with `rsp_sum`=5, `rsp_carry`=0, `rsp_timeout`=0.
- **Overflow, delayed responder.** a=9, b=8 against a responder with `res_valid` 2 cycles late → `rsp_sum`=1, `rsp_carry`=1, `rsp_valid` 5 cycles after accept.
- **Timeout.** `TIMEOUT`=8, `res_valid` tied 0 → `rsp_valid`=1, `rsp_timeout`=1, `rsp_sum`=0 at edge E2+8. Next transaction after `rsp_ready` completes normally.
- **Backpressure.** `rsp_ready`=0 for 5 cycles with a second `req_valid` pending → `rsp_sum`/`rsp_valid` stable, `req_ready`=0, `p_seq`=0. Raise `rsp_ready` → IDLE next edge, second request accepted the edge after.
- **Reset mid-transaction.** Assert `rst` during SEND_P2 → `p_seq`=0 and `busy`=0 immediately. No `rsp_valid` after release. Next request a=1, b=1 → `rsp_sum`=2.
